// File: rtl/i2c_regfile_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_regfile_arbiter_if
// Description : Bus bundle for the register-file arbiter: I2C requester,
//               host requester, RAM primitive and event FIFO signals.
//               slave  = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_regfile_arbiter_if #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int EVT_DEPTH = 8
);
  // I2C slave engine side
  logic                         i2c_req;
  logic                         i2c_we;
  logic [ADDR_W-1:0]            i2c_addr;
  logic [DATA_W-1:0]            i2c_wdata;
  logic                         i2c_gnt;
  logic [DATA_W-1:0]            i2c_rdata;
  logic                         i2c_rvalid;
  // Host command side
  logic                         host_req;
  logic                         host_we;
  logic [ADDR_W-1:0]            host_addr;
  logic [DATA_W-1:0]            host_wdata;
  logic                         host_gnt;
  logic [DATA_W-1:0]            host_rdata;
  logic                         host_rvalid;
  // RAM primitive
  logic                         ram_en;
  logic                         ram_we;
  logic [ADDR_W-1:0]            ram_addr;
  logic [DATA_W-1:0]            ram_wdata;
  logic [DATA_W-1:0]            ram_rdata;
  // Event FIFO
  logic                         evt_valid;
  logic [ADDR_W-1:0]            evt_addr;
  logic                         evt_ready;
  logic                         evt_overflow;
  logic                         evt_clear;
  logic [$clog2(EVT_DEPTH):0]   evt_count;

  modport slave (
    input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
    output i2c_gnt, i2c_rdata, i2c_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output evt_valid, evt_addr, evt_overflow, evt_count,
    input  evt_ready, evt_clear
  );

  modport master (
    output i2c_req, i2c_we, i2c_addr, i2c_wdata,
    input  i2c_gnt, i2c_rdata, i2c_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  evt_valid, evt_addr, evt_overflow, evt_count,
    output evt_ready, evt_clear
  );
endinterface
`default_nettype wire

// File: rtl/i2c_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_regfile_arbiter
// Description : Shares one single-port register RAM between the I2C slave
//               engine (primary) and the host command path (secondary, with
//               anti-starvation), and logs every I2C-written address in a
//               small event FIFO for upload by the host.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_regfile_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int EVT_DEPTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_regfile_arbiter_if.slave  bus
);

  localparam int c_PTR_W = $clog2(EVT_DEPTH);
  localparam int c_CNT_W = $clog2(EVT_DEPTH) + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(EVT_DEPTH);

  logic [c_STV_W-1:0] r_starve;
  logic               w_host_prio;
  logic               w_i2c_gnt;
  logic               w_host_gnt;

  logic               r_i2c_rvalid;
  logic [DATA_W-1:0]  r_i2c_rdata;
  logic               r_host_rvalid;
  logic [DATA_W-1:0]  r_host_rdata;

  logic [ADDR_W-1:0]  r_mem [EVT_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_push_ok;
  logic               w_mem_we;
  logic [c_PTR_W-1:0] w_mem_idx;

  // --------------------------------------------------------------------------
  // Arbitration: I2C wins ties unless the host has been denied long enough.
  // --------------------------------------------------------------------------
  assign w_host_prio = (r_starve >= c_STV_MAX);
  assign w_i2c_gnt   = bus.i2c_req && !(bus.host_req && w_host_prio);
  assign w_host_gnt  = bus.host_req && !w_i2c_gnt;

  assign bus.i2c_gnt  = w_i2c_gnt;
  assign bus.host_gnt = w_host_gnt;

  // Steer the granted requester onto the RAM port in the same cycle.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (w_i2c_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.i2c_we;
      bus.ram_addr  = bus.i2c_addr;
      bus.ram_wdata = bus.i2c_wdata;
    end else if (w_host_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.host_we;
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
    end
  end

  // Count consecutive denied host cycles, saturating; cleared on a host grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_host_gnt) begin
      r_starve <= '0;
    end else if (bus.host_req && (r_starve < c_STV_MAX)) begin
      r_starve <= r_starve + c_STV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Read return. The RAM presents data one cycle after the access, so the
  // valid pulse is registered and the data is passed straight through in that
  // cycle, then held in a per-side register until the next read on that side.
  // --------------------------------------------------------------------------
  // Track outstanding reads per side and capture the returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i2c_rvalid  <= 1'b0;
      r_i2c_rdata   <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_i2c_rvalid  <= w_i2c_gnt && !bus.i2c_we;
      r_host_rvalid <= w_host_gnt && !bus.host_we;
      if (r_i2c_rvalid) begin
        r_i2c_rdata <= bus.ram_rdata;
      end
      if (r_host_rvalid) begin
        r_host_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.i2c_rvalid  = r_i2c_rvalid;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.i2c_rdata   = r_i2c_rvalid  ? bus.ram_rdata : r_i2c_rdata;
  assign bus.host_rdata  = r_host_rvalid ? bus.ram_rdata : r_host_rdata;

  // --------------------------------------------------------------------------
  // Event FIFO of I2C-written addresses.
  // --------------------------------------------------------------------------
  assign w_push    = w_i2c_gnt && bus.i2c_we;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  assign w_pop     = !w_empty && bus.evt_ready;
  // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);
  // A clear restarts the FIFO, so a coincident push goes to slot 0.
  assign w_mem_we  = bus.evt_clear ? w_push : w_push_ok;
  assign w_mem_idx = bus.evt_clear ? '0 : r_wptr;

  // Entry storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= bus.i2c_addr;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.evt_clear) begin
      r_rptr  <= '0;
      r_wptr  <= w_push ? c_PTR_W'(1) : '0;
      r_count <= w_push ? c_CNT_W'(1) : '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.evt_valid    = !w_empty;
  assign bus.evt_addr     = w_empty ? '0 : r_mem[r_rptr];
  assign bus.evt_count    = r_count;
  assign bus.evt_overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/i2c_regfile_arbiter.md
Name: i2c_regfile_arbiter

Overview:
Arbitrates one single-port 256x8 register RAM between two requesters. The I2C slave engine side is the primary requester. The USB-CDC host command side is secondary and is used by the PC to preload and read back the emulated slave register image.
The block records every address written by the I2C master in a small event FIFO, so the host can upload changed registers.
It sits between the I2C slave wrapper's register-access logic, the CDC command parser and the RAM primitive.

Parameters:
ADDR_W, 8, RAM address width (256 entries)
DATA_W, 8, RAM data width
EVT_DEPTH, 8, event FIFO depth; power of two, >=2
STARVE_LIMIT, 4, consecutive denied host-request cycles before the host gets priority

Ports:
clk  in  1  system clock
rst_n  in  1  reset
i2c_req  in  1  I2C-side access request, held until granted
i2c_we  in  1  1=write, 0=read
i2c_addr  in  ADDR_W  I2C-side address
i2c_wdata  in  DATA_W  I2C-side write data
i2c_gnt  out  1  combinational; request accepted this cycle
i2c_rdata  out  DATA_W  read data
i2c_rvalid  out  1  read data valid pulse
host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host-side equivalents
host_gnt  out  1  combinational accept
host_rdata  out  DATA_W  read data
host_rvalid  out  1  read data valid pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en&&!ram_we
evt_valid  out  1  event FIFO non-empty
evt_addr  out  ADDR_W  head entry: address written by the I2C master
evt_ready  in  1  pop the head when evt_valid=1
evt_overflow  out  1  sticky: an event was dropped
evt_clear  in  1  flush the FIFO and clear evt_overflow
evt_count  out  clog2(EVT_DEPTH)+1  number of entries held

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low. Reset empties the FIFO and clears the starve counter, evt_overflow, i2c_rvalid, host_rvalid, i2c_rdata and host_rdata (all 0). Combinational outputs are 0 while no request is present.
- Arbitration each cycle:
  - Only one requester active: that side is granted.
  - Both active: I2C is granted, unless starve_cnt >= STARVE_LIMIT, in which case the host is granted.
  - The granted side's signals drive ram_* in the same cycle; ram_en=1.
- At most one grant per cycle; i2c_gnt and host_gnt are never both 1.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on host_req&&!host_gnt.
  - Resets to 0 on host_gnt.
  - Holds otherwise.
- Read latency is one cycle. A read granted in cycle N gives x_rvalid=1 and x_rdata=ram_rdata, registered, in cycle N+1, on the side granted in N only.
  - rvalid is a 1-cycle pulse.
  - x_rdata holds its last value until the next read on that side.
- Back-to-back grants in consecutive cycles are permitted (full throughput).
- A write issues no rvalid.
- Event FIFO:
  - Push: every granted I2C write pushes i2c_addr. Host writes never push.
  - Pop: evt_valid&&evt_ready pops. evt_addr is the head entry, shown directly from FIFO storage with no extra latency.
  - Full with push and no pop: the new address is dropped and evt_overflow sets.
  - Full with push and pop in the same cycle: both succeed, no overflow.
  - Empty with pop: ignored.
  - Read/write pointers wrap modulo EVT_DEPTH. evt_count ranges 0..EVT_DEPTH.
  - evt_clear: empties the FIFO and clears evt_overflow. A push in the same cycle is kept as the sole entry (count=1). A pop in that cycle is ignored.
- Duplicate addresses are not merged. Each write produces one entry.
- Requests with x_req=0 are ignored regardless of the other inputs. A requester that drops x_req before being granted gets no access.
- Async reset mid-read: the pending rvalid is cancelled.

Test Plan:
1. Host writes 0x5A to 0x10, then reads 0x10 with no I2C activity -> host_gnt in the request cycle; host_rvalid 1 cycle later with host_rdata=0x5A; evt_count=0.
2. I2C writes 0x11 to 0x20 and 0x22 to 0x21 back-to-back -> two i2c_gnt cycles; evt_addr=0x20 then 0x21 after one pop; evt_count goes 1,2,1.
3. i2c_req and host_req held high continuously, STARVE_LIMIT=4 -> I2C granted 4 cycles, then host granted 1 cycle, pattern repeats; never a dual grant.
4. Nine I2C writes to addresses 0..8 with evt_ready=0 -> evt_count=8; evt_overflow=1; popping yields 0..7. Then, full with push and pop in the same cycle -> count stays 8, no new overflow.
5. evt_clear coincident with an I2C write to 0x33 on a full FIFO -> evt_count=1, evt_addr=0x33, evt_overflow=0.
6. rst_n asserted the cycle after a granted I2C read -> i2c_rvalid stays 0, FIFO empty; normal service resumes after release.
